// File: rtl/mips_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU class and
// funct encodings, and the branch-flush state machine states.
package mips_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluOp_e;

    localparam logic [2:0] FUNCT_ADD = 3'b000;
    localparam logic [2:0] FUNCT_SUB = 3'b001;
    localparam logic [2:0] FUNCT_AND = 3'b010;
    localparam logic [2:0] FUNCT_OR  = 3'b011;
    localparam logic [2:0] FUNCT_SLT = 3'b100;
    localparam logic [2:0] FUNCT_XOR = 3'b101;
    localparam logic [2:0] FUNCT_NOR = 3'b110;
    localparam logic [2:0] FUNCT_SRL = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exState_e;

endpackage

// File: rtl/alu16.sv
// Purely combinational ALU: the ALU class selects a fixed operation, or
// defers to the funct field for R-type instructions.
module alu16
    import mips_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [1:0]   i_ALUOp,
    input  logic [2:0]   i_funct,
    output logic [W-1:0] o_result
);

    logic w_lessThan;

    assign w_lessThan = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = '0;
        case (i_ALUOp)
            ALUOP_ADD: o_result = i_a + i_b;
            ALUOP_SUB: o_result = i_a - i_b;
            ALUOP_OR:  o_result = i_a | i_b;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_result = i_a + i_b;
                    FUNCT_SUB: o_result = i_a - i_b;
                    FUNCT_AND: o_result = i_a & i_b;
                    FUNCT_OR:  o_result = i_a | i_b;
                    FUNCT_SLT: o_result = {{(W-1){1'b0}}, w_lessThan};
                    FUNCT_XOR: o_result = i_a ^ i_b;
                    FUNCT_NOR: o_result = ~(i_a | i_b);
                    FUNCT_SRL: o_result = i_a >> 1;
                    default:   o_result = '0;
                endcase
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: ALU, EX/MEM register, branch resolution and a
// small FSM that squashes the wrong-path slots behind a taken branch.
module execute_stage #(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] PC_plus_two,
    input  logic [2:0]        rt,
    input  logic [2:0]        rd,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic [1:0]        ALUOp,
    output logic              PC_Src,
    output logic [DATA_W-1:0] branch_target,
    output logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_alu_result,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [2:0]        ex_dest,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite
);
    import mips_pkg::*;

    localparam int CNT_W = (FLUSH_SLOTS < 2) ? 1 : $clog2(FLUSH_SLOTS + 1);

    exState_e          r_state;
    exState_e          w_nextState;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_nextCount;
    logic              r_pcSrc;
    logic [DATA_W-1:0] r_branchTarget;
    logic              r_exValid;
    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_storeData;
    logic [2:0]        r_dest;
    logic              r_memtoReg;
    logic              r_regWrite;
    logic              r_memRead;
    logic              r_memWrite;

    logic              w_accept;
    logic              w_taken;
    logic [DATA_W-1:0] w_operandB;
    logic [DATA_W-1:0] w_aluResult;
    logic [DATA_W-1:0] w_target;

    assign w_accept   = id_valid && !stall && (r_state == ST_IDLE);
    assign w_taken    = w_accept && Branch && (read_data_1 == read_data_2);
    assign w_operandB = ALUSrc ? immediate : read_data_2;
    assign w_target   = PC_plus_two + (immediate << 1);

    alu16 #(.W(DATA_W)) u_alu (
        .i_a      (read_data_1),
        .i_b      (w_operandB),
        .i_ALUOp  (ALUOp),
        .i_funct  (immediate[2:0]),
        .o_result (w_aluResult)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_taken && (FLUSH_SLOTS > 0)) begin
                    w_nextState = ST_FLUSH;
                    w_nextCount = CNT_W'(FLUSH_SLOTS);
                end
            end
            ST_FLUSH: begin
                if (r_count <= CNT_W'(1)) begin
                    w_nextState = ST_IDLE;
                    w_nextCount = '0;
                end else begin
                    w_nextCount = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    // A stall freezes the flush countdown and any pending redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_pcSrc        <= 1'b0;
            r_branchTarget <= '0;
        end else if (!stall) begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_pcSrc <= w_taken;
            if (w_taken) begin
                r_branchTarget <= w_target;
            end
        end
    end

    // A taken branch still occupies the slot but must not write anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid   <= 1'b0;
            r_aluResult <= '0;
            r_storeData <= '0;
            r_dest      <= '0;
            r_memtoReg  <= 1'b0;
            r_regWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
        end else if (!stall) begin
            r_exValid   <= w_accept;
            r_aluResult <= w_accept ? w_aluResult : '0;
            r_storeData <= w_accept ? read_data_2 : '0;
            r_dest      <= w_accept ? (RegDst ? rd : rt) : 3'd0;
            r_memtoReg  <= w_accept && MemtoReg;
            r_regWrite  <= w_accept && RegWrite && !w_taken;
            r_memRead   <= w_accept && MemRead && !w_taken;
            r_memWrite  <= w_accept && MemWrite && !w_taken;
        end
    end

    assign PC_Src        = r_pcSrc;
    assign branch_target = r_branchTarget;
    assign flush         = (r_state == ST_FLUSH);
    assign ex_valid      = r_exValid;
    assign ex_alu_result = r_aluResult;
    assign ex_store_data = r_storeData;
    assign ex_dest       = r_dest;
    assign ex_MemtoReg   = r_memtoReg;
    assign ex_RegWrite   = r_regWrite;
    assign ex_MemRead    = r_memRead;
    assign ex_MemWrite   = r_memWrite;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: DATA_W, 16, datapath/PC width; FLUSH_SLOTS, 2, wrong-path instructions squashed after a taken branch.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: stall  in  1  hold all state; inputs ignored.
REQ-006 Port: id_valid  in  1  decode presents a real instruction.
REQ-007 Port: read_data_1, read_data_2  in  DATA_W  register operands.
REQ-008 Port: immediate  in  DATA_W  sign-extended immediate; bits [2:0] are funct.
REQ-009 Port: PC_plus_two  in  DATA_W  PC of the instruction + 2.
REQ-010 Port: rt, rd  in  3 each  destination candidates.
REQ-011 Port: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  decode controls.
REQ-012 Port: ALUOp  in  2  ALU class.
REQ-013 Port: PC_Src  out  1  one-cycle redirect pulse to fetch.
REQ-014 Port: branch_target  out  DATA_W  redirect PC; valid while PC_Src=1.
REQ-015 Port: flush  out  1  high while squashing wrong-path slots.
REQ-016 Port: ex_valid, ex_alu_result(DATA_W), ex_store_data(DATA_W), ex_dest(3), ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite  out  EX/MEM register.

Function
REQ-017 An instruction is accepted on a rising edge when id_valid=1, stall=0, and flush=0.
REQ-018 Latency: exactly 1 cycle from acceptance to ex_valid=1 with its results.
REQ-019 Cycles with no acceptance and stall=0 load ex_valid=0 and all ex_* controls as 0; stall=1 holds every output and all state unchanged.
REQ-020 ALUOp 00=add, 01=sub, 11=or; 10 decodes funct: 000 add, 001 sub, 010 and, 011 or, 100 signed slt (result 1/0), 101 xor, 110 nor, 111 logical right shift by 1.
REQ-021 Operand B = immediate when ALUSrc=1, else read_data_2; arithmetic wraps modulo 2^DATA_W, no overflow flag.
REQ-022 ex_dest = rd if RegDst=1 else rt; ex_store_data = read_data_2.
REQ-023 Branch taken iff accepted, Branch=1, and read_data_1==read_data_2; a taken branch forces ex_RegWrite=ex_MemWrite=ex_MemRead=0.
REQ-024 branch_target = PC_plus_two + (immediate<<1), modulo 2^DATA_W, registered with PC_Src.
REQ-025 PC_Src is 1 for exactly one unstalled cycle following the taken-branch edge; otherwise 0.
REQ-026 FSM: IDLE -> FLUSH on taken branch (counter loaded with FLUSH_SLOTS); in FLUSH each unstalled cycle decrements; counter reaching 0 -> IDLE.
REQ-027 flush=1 exactly in FLUSH; id_valid is ignored (squashed, including Branch) in FLUSH.
REQ-028 stall during FLUSH freezes the counter, flush, and a pending PC_Src.

Reset
REQ-029 rst=1 at an edge: FSM=IDLE, counter=0, PC_Src=0, flush=0, branch_target=0, ex_valid=0, all ex_* = 0; rst overrides stall and any in-progress flush.

Structure
REQ-030 Shared package mips_pkg holds DATA_W, ALUOp and funct encodings, and FSM state enum.
REQ-031 Combinational ALU is a sub-module alu16 (a, b, ALUOp, funct -> result); the FSM and registers stay in execute_stage.

Verification
REQ-032 ALUOp=10, funct=100, rd1=0xFFFF, rd2=0x0001 -> next cycle ex_alu_result=0x0001, ex_valid=1.
REQ-033 ALUOp=00, ALUSrc=1, rd1=0xFFFE, imm=0x0004 -> ex_alu_result=0x0002 (wrap).
REQ-034 Branch=1, rd1=rd2=0x0005, PC_plus_two=0x0010, imm=0xFFFC -> PC_Src one cycle, branch_target=0x0008, flush 2 cycles, two following id_valid instructions give ex_valid=0.
REQ-035 Taken branch then stall=1 for 3 cycles during FLUSH -> flush lasts 2 unstalled cycles + 3, outputs frozen.
REQ-036 rst=1 during FLUSH with stall=1 -> next cycle flush=0, PC_Src=0, ex_valid=0; next valid instruction accepted.
